// File: rtl/hvsp_frame_engine_pkg.sv
// Shared definitions for the HVSP frame engine: FSM state encodings,
// default timing constants and the native HVSP frame width.
package hvsp_frame_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_HIGH   = 3'd2,
    ST_LOW    = 3'd3,
    ST_POLL   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam int HVSP_FRAME_BITS  = 11;
  localparam int DEF_LANES        = 2;
  localparam int DEF_T_SETUP      = 3;
  localparam int DEF_T_HI_PRE     = 3;
  localparam int DEF_T_HI_POST    = 3;
  localparam int DEF_T_LOW        = 4;
  localparam int DEF_POLL_TIMEOUT = 12000;
  localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/hvsp_cmd_fifo.sv
// Two-entry command queue holding {poll flag, lane data}; flush empties it
// in one cycle and overrides any simultaneous push or pop.
module hvsp_cmd_fifo
  import hvsp_frame_engine_pkg::*;
#(
  parameter int W = HVSP_FRAME_BITS * DEF_LANES + 1
) (
  input  logic         osc,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hvsp_frame_engine.sv
// HVSP serial frame engine: shifts queued multi-lane frames out MSB first
// under a generated SCI clock, captures SDO and optionally polls for ready.
module hvsp_frame_engine
  import hvsp_frame_engine_pkg::*;
#(
  parameter int FRAME_BITS   = HVSP_FRAME_BITS,
  parameter int LANES        = DEF_LANES,
  parameter int T_SETUP      = DEF_T_SETUP,
  parameter int T_HI_PRE     = DEF_T_HI_PRE,
  parameter int T_HI_POST    = DEF_T_HI_POST,
  parameter int T_LOW        = DEF_T_LOW,
  parameter int POLL_TIMEOUT = DEF_POLL_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                        osc,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [LANES*FRAME_BITS-1:0] cmd_data,
  input  logic                        cmd_poll,
  input  logic                        abort,
  input  logic                        sci_manual,
  output logic                        busy,
  output logic                        rx_valid,
  output logic [FRAME_BITS-1:0]       rx_data,
  output logic                        rx_timeout,
  output logic                        sci,
  output logic [LANES-1:0]            sd_out,
  input  logic                        sdo_in
);

  localparam int DATA_W = LANES * FRAME_BITS;
  localparam int IDX_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  state_t                  state;
  logic [CNT_W-1:0]        dly_cnt;
  logic [CNT_W-1:0]        poll_cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [IDX_W-1:0]        cur_pos;
  logic [DATA_W-1:0]       frame;
  logic                    poll_flag;
  logic [FRAME_BITS-1:0]   rx_shift;
  logic                    sdo_meta;
  logic                    sdo_s;
  logic [DATA_W-1:0]       fifo_data;
  logic                    fifo_poll;
  logic [1:0]              fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;

  // Bit position (MSB first) of each lane for a given frame index
  function automatic logic [LANES-1:0] lane_bits(input logic [DATA_W-1:0] d,
                                                 input logic [IDX_W-1:0] pos);
    logic [FRAME_BITS-1:0] w;
    lane_bits = '0;
    for (int k = 0; k < LANES; k++) begin
      w            = d[k*FRAME_BITS +: FRAME_BITS];
      lane_bits[k] = w[pos];
    end
  endfunction

  assign cmd_ready = !fifo_full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty && !abort;
  assign busy      = (state != ST_IDLE) || (fifo_count != 2'd0);
  assign cur_pos   = LAST_IDX - bit_idx;

  hvsp_cmd_fifo #(.W(DATA_W + 1)) u_fifo (
    .osc   (osc),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   ({cmd_poll, cmd_data}),
    .dout  ({fifo_poll, fifo_data}),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      sdo_meta <= 1'b0;
      sdo_s    <= 1'b0;
    end else begin
      sdo_meta <= sdo_in;
      sdo_s    <= sdo_meta;
    end
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dly_cnt    <= '0;
      poll_cnt   <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      poll_flag  <= 1'b0;
      rx_shift   <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_timeout <= 1'b0;
      sci        <= 1'b0;
      sd_out     <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        sci    <= 1'b0;
        sd_out <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            sci    <= sci_manual;
            sd_out <= '0;
            if (!fifo_empty) begin
              frame     <= fifo_data;
              poll_flag <= fifo_poll;
              bit_idx   <= '0;
              dly_cnt   <= CNT_W'(T_SETUP - 1);
              sd_out    <= lane_bits(fifo_data, LAST_IDX);
              sci       <= 1'b0;
              state     <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (dly_cnt == '0) begin
              sci     <= 1'b1;
              dly_cnt <= CNT_W'(T_HI_PRE + T_HI_POST - 1);
              state   <= ST_HIGH;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          // SDO is sampled in the last cycle before the post-sample hold
          ST_HIGH: begin
            if (dly_cnt == CNT_W'(T_HI_POST)) rx_shift[cur_pos] <= sdo_s;
            if (dly_cnt == '0) begin
              sci     <= 1'b0;
              dly_cnt <= CNT_W'(T_LOW - 1);
              state   <= ST_LOW;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          ST_LOW: begin
            if (dly_cnt != '0) begin
              dly_cnt <= dly_cnt - 1'b1;
            end else if (bit_idx == LAST_IDX) begin
              if (poll_flag) begin
                poll_cnt <= '0;
                state    <= ST_POLL;
              end else begin
                rx_valid   <= 1'b1;
                rx_data    <= rx_shift;
                rx_timeout <= 1'b0;
                state      <= ST_FINISH;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              sd_out  <= lane_bits(frame, cur_pos - 1'b1);
              dly_cnt <= CNT_W'(T_SETUP - 1);
              state   <= ST_SETUP;
            end
          end
          ST_POLL: begin
            if (sdo_s) begin
              rx_valid   <= 1'b1;
              rx_data    <= rx_shift;
              rx_timeout <= 1'b0;
              state      <= ST_FINISH;
            end else if (poll_cnt == CNT_W'(POLL_TIMEOUT - 1)) begin
              rx_valid   <= 1'b1;
              rx_data    <= rx_shift;
              rx_timeout <= 1'b1;
              state      <= ST_FINISH;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
          ST_FINISH: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hvsp_frame_engine.sv
// Scoreboard bench for hvsp_frame_engine: default build plus an 8-bit,
// 3-lane build sharing clock and reset.
module tb_hvsp_frame_engine;

  localparam int FB  = 11;
  localparam int LN  = 2;
  localparam int FB2 = 8;
  localparam int LN2 = 3;

  logic             osc = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [FB*LN-1:0] cmd_data = '0;
  logic             cmd_poll = 1'b0;
  logic             abort = 1'b0;
  logic             sci_manual = 1'b0;
  logic             sdo_in = 1'b0;
  logic             cmd_ready, busy, rx_valid, rx_timeout, sci;
  logic [FB-1:0]    rx_data;
  logic [LN-1:0]    sd_out;

  logic               cmd_valid2 = 1'b0;
  logic [FB2*LN2-1:0] cmd_data2 = '0;
  logic               cmd_poll2 = 1'b0;
  logic               abort2 = 1'b0;
  logic               sci_manual2 = 1'b0;
  logic               sdo_in2 = 1'b1;
  logic               cmd_ready2, busy2, rx_valid2, rx_timeout2, sci2;
  logic [FB2-1:0]     rx_data2;
  logic [LN2-1:0]     sd_out2;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int            cyc;
    logic [FB-1:0] data;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];
  exp_t mon_e;
  exp_t mon_e2;

  hvsp_frame_engine dut (
    .osc(osc), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_poll(cmd_poll), .abort(abort),
    .sci_manual(sci_manual), .busy(busy), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_timeout(rx_timeout), .sci(sci), .sd_out(sd_out),
    .sdo_in(sdo_in)
  );

  hvsp_frame_engine #(.FRAME_BITS(FB2), .LANES(LN2)) dut2 (
    .osc(osc), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_data(cmd_data2), .cmd_poll(cmd_poll2), .abort(abort2),
    .sci_manual(sci_manual2), .busy(busy2), .rx_valid(rx_valid2),
    .rx_data(rx_data2), .rx_timeout(rx_timeout2), .sci(sci2), .sd_out(sd_out2),
    .sdo_in(sdo_in2)
  );

  always #5 osc = ~osc;
  always @(posedge osc) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors pop the scoreboard whenever a completion pulse appears
  always @(negedge osc) begin
    if (rst_n && rx_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rx: got data %0h at cycle %0d, expected no pulse", rx_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rx_cycle", cyc, mon_e.cyc);
        checkOutput("rx_data", 32'(rx_data), 32'(mon_e.data));
        checkOutput("rx_timeout", 32'(rx_timeout), 32'(mon_e.tmo));
      end
    end
  end

  always @(negedge osc) begin
    if (rst_n && rx_valid2) begin
      if (sb2.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rx2: got data %0h at cycle %0d, expected no pulse", rx_data2, cyc);
      end else begin
        mon_e2 = sb2.pop_front();
        checkOutput("rx2_cycle", cyc, mon_e2.cyc);
        checkOutput("rx2_data", 32'(rx_data2), 32'(mon_e2.data));
        checkOutput("rx2_timeout", 32'(rx_timeout2), 32'(mon_e2.tmo));
      end
    end
  end

  // SDO device model and SCI edge recorder for the default build
  logic [FB-1:0] sdo_pat = 11'h2A9;
  int            sdo_bit = 0;
  logic          poll_mode = 1'b0;
  logic          sci_d = 1'b0;
  int            rise_q[$];
  int            fall_q[$];
  logic [FB-1:0] cap0 = '0;
  logic [FB-1:0] cap1 = '0;

  always @(posedge osc) begin
    #1;
    if (!sci_d && sci) begin
      rise_q.push_back(cyc);
      cap0 = {cap0[FB-2:0], sd_out[0]};
      cap1 = {cap1[FB-2:0], sd_out[1]};
    end
    if (sci_d && !sci) begin
      fall_q.push_back(cyc);
      sdo_bit = sdo_bit + 1;
      if (sdo_bit >= FB) begin
        sdo_bit = 0;
        sdo_in  = poll_mode ? 1'b0 : sdo_pat[FB-1];
      end else begin
        sdo_in = sdo_pat[FB-1-sdo_bit];
      end
    end
    sci_d = sci;
  end

  logic           sci2_d = 1'b0;
  int             rise2 = 0;
  logic [FB2-1:0] cap2 [LN2];

  always @(posedge osc) begin
    #1;
    if (!sci2_d && sci2) begin
      rise2++;
      for (int k = 0; k < LN2; k++) cap2[k] = {cap2[k][FB2-2:0], sd_out2[k]};
    end
    sci2_d = sci2;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge osc);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [FB*LN-1:0] data, input logic poll, output int acc);
    int guard = 0;
    cmd_data  = data;
    cmd_poll  = poll;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 2000) begin
      tick(1);
      guard++;
    end
    acc = cyc;
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: cmd_ready stayed 0, expected 1 within 2000 cycles");
    end
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic expectRx(input int c, input logic [FB-1:0] d, input logic t);
    exp_t e;
    e.cyc = c; e.data = d; e.tmo = t;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input int max_cycles);
    int g = 0;
    while ((sb.size() != 0 || sb2.size() != 0) && g < max_cycles) begin
      tick(1);
      g++;
    end
    if (sb.size() != 0 || sb2.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size() + sb2.size());
      sb.delete();
      sb2.delete();
    end
    tick(3);
  endtask

  task automatic startFrame();
    sdo_bit = 0;
    sdo_in  = sdo_pat[FB-1];
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, acc2, acc3, acc4, p, n, g;
    tick(3);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_sci", 32'(sci), 32'd0);
    checkOutput("reset_sd_out", 32'(sd_out), 32'd0);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] idle SCI follows sci_manual");
    sci_manual = 1'b1;
    tick(1);
    checkOutput("sci_manual_hi", 32'(sci), 32'd1);
    sci_manual = 1'b0;
    tick(2);
    checkOutput("sci_manual_lo", 32'(sci), 32'd0);

    $display("[TB] single frame SDI=200 SII=130");
    rise_q.delete();
    fall_q.delete();
    poll_mode = 1'b0;
    startFrame();
    applyStimulus({11'h130, 11'h200}, 1'b0, acc);
    expectRx(acc + 145, 11'h2A9, 1'b0);
    waitDrain(400);
    checkOutput("sci_pulse_count", rise_q.size(), 32'd11);
    if (rise_q.size() == 11 && fall_q.size() == 11) begin
      checkOutput("first_rise", rise_q[0], acc + 5);
      for (int i = 0; i < 11; i++) checkOutput("sci_high_width", fall_q[i] - rise_q[i], 32'd6);
      for (int i = 0; i < 10; i++) checkOutput("sci_low_width", rise_q[i+1] - fall_q[i], 32'd7);
    end
    checkOutput("sdi_pattern", 32'(cap0), 32'h200);
    checkOutput("sii_pattern", 32'(cap1), 32'h130);

    $display("[TB] queue of four commands");
    startFrame();
    applyStimulus({11'h001, 11'h7FE}, 1'b0, acc);
    applyStimulus({11'h555, 11'h2AA}, 1'b0, acc2);
    applyStimulus({11'h0F0, 11'h70F}, 1'b0, acc3);
    checkOutput("queue_accept2", acc2, acc + 1);
    checkOutput("queue_accept3", acc3, acc + 2);
    checkOutput("queue_full_ready", 32'(cmd_ready), 32'd0);
    expectRx(acc + 145, 11'h2A9, 1'b0);
    expectRx(acc + 290, 11'h2A9, 1'b0);
    expectRx(acc + 435, 11'h2A9, 1'b0);
    applyStimulus({11'h123, 11'h456}, 1'b0, acc4);
    checkOutput("queue_accept4", acc4, acc + 147);
    expectRx(acc + 580, 11'h2A9, 1'b0);
    waitDrain(1000);

    $display("[TB] poll with device ready");
    poll_mode = 1'b1;
    startFrame();
    applyStimulus({11'h3FF, 11'h000}, 1'b1, acc);
    p = acc + 145;
    expectRx(p + 103, 11'h2A9, 1'b0);
    g = 0;
    while (cyc < p + 100 && g < 1000) begin
      tick(1);
      g++;
    end
    sdo_in = 1'b1;
    waitDrain(300);
    sdo_in = 1'b0;

    $display("[TB] poll timeout");
    startFrame();
    applyStimulus({11'h000, 11'h3FF}, 1'b1, acc);
    expectRx(acc + 145 + 12000, 11'h2A9, 1'b1);
    waitDrain(12400);
    poll_mode = 1'b0;

    $display("[TB] abort at bit 5 with one command queued");
    rise_q.delete();
    startFrame();
    applyStimulus({11'h7FF, 11'h7FF}, 1'b0, acc);
    g = 0;
    while (rise_q.size() < 6 && g < 200) begin
      tick(1);
      g++;
    end
    applyStimulus({11'h7FF, 11'h7FF}, 1'b0, acc2);
    abort = 1'b1;
    #1;
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    tick(1);
    abort = 1'b0;
    checkOutput("abort_sci", 32'(sci), 32'd0);
    checkOutput("abort_sd_out", 32'(sd_out), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    n = rise_q.size();
    tick(400);
    checkOutput("abort_no_resend", rise_q.size(), n);
    checkOutput("abort_idle_busy", 32'(busy), 32'd0);

    $display("[TB] reset mid-frame");
    startFrame();
    applyStimulus({11'h7FF, 11'h7FF}, 1'b0, acc);
    tick(50);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_sci", 32'(sci), 32'd0);
    checkOutput("rst_sd_out", 32'(sd_out), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] 8-bit 3-lane build");
    rise2 = 0;
    cmd_data2  = {8'hF0, 8'h3C, 8'hA5};
    cmd_valid2 = 1'b1;
    g = 0;
    while (!cmd_ready2 && g < 100) begin
      tick(1);
      g++;
    end
    acc = cyc;
    tick(1);
    cmd_valid2 = 1'b0;
    mon_e.cyc = acc + 106; mon_e.data = 11'h0FF; mon_e.tmo = 1'b0;
    sb2.push_back(mon_e);
    waitDrain(400);
    checkOutput("lane8_pulses", rise2, 32'd8);
    checkOutput("lane8_0", 32'(cap2[0]), 32'hA5);
    checkOutput("lane8_1", 32'(cap2[1]), 32'h3C);
    checkOutput("lane8_2", 32'(cap2[2]), 32'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
